// File: rtl/io_pkg.sv
// Shared definitions for the io input scanner: register map offsets and scan FSM encoding.
package io_pkg;

    localparam logic [5:0] IO_IN_BASE = 6'b100000;
    localparam logic [5:0] IO_STATUS  = 6'b110000;

    typedef enum logic [1:0] {
        SAMPLE = 2'd0,
        SETTLE = 2'd1,
        COMMIT = 2'd2
    } scan_state_t;

endpackage

// File: rtl/io_scan_read_mux.sv
// Combinational io read path: decodes addr[7:2] into a debounced port value, the
// change-status word, or zero.
module io_scan_read_mux
    import io_pkg::*;
#(
    parameter int NPORTS = 2
) (
    input  logic [5:0]           sel,
    input  logic [NPORTS*32-1:0] stable_flat,
    input  logic [NPORTS-1:0]    chg,
    output logic [31:0]          rd_data
);

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        rd_data = '0;
        if (sel == IO_STATUS) begin
            rd_data[NPORTS-1:0] = chg;
        end
        for (int i = 0; i < NPORTS; i++) begin
            if (sel == IO_IN_BASE + 6'(i)) begin
                rd_data = stable_flat[32*i +: 32];
            end
        end
    end

endmodule

// File: rtl/io_input_scanner.sv
// Round-robin debouncer for the memory-mapped input ports; publishes stable values and a
// sticky, clear-on-read change-status word, with an optional change interrupt.
module io_input_scanner
    import io_pkg::*;
#(
    parameter int NPORTS   = 2,
    parameter int DEBOUNCE = 4
) (
    input  logic                 io_clk,
    input  logic                 resetn,
    input  logic [NPORTS*32-1:0] in_ports,
    input  logic [31:0]          addr,
    input  logic                 rd_en,
    input  logic                 irq_en,
    output logic [31:0]          io_read_data,
    output logic                 change_irq
);

    localparam int PW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam logic [PW-1:0] LAST_PORT = PW'(NPORTS - 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE - 1);

    scan_state_t          state, state_nxt;
    logic [PW-1:0]        port_idx;
    logic [CW-1:0]        cnt;
    logic [31:0]          cand;
    logic [31:0]          stable [NPORTS];
    logic [NPORTS-1:0]    chg, chg_set, chg_clr;
    logic [31:0]          raw_sel, stable_sel;
    logic [NPORTS*32-1:0] stable_flat;
    logic                 raw_match;
    logic                 load_cand, cnt_inc, next_port, commit_new;
    logic                 unused_addr;

    assign unused_addr = ^{addr[31:8], addr[1:0]};

    always_comb begin
        raw_sel    = '0;
        stable_sel = '0;
        for (int i = 0; i < NPORTS; i++) begin
            stable_flat[32*i +: 32] = stable[i];
            if (port_idx == PW'(i)) begin
                raw_sel    = in_ports[32*i +: 32];
                stable_sel = stable[i];
            end
        end
    end

    assign raw_match = (raw_sel == cand);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge io_clk or negedge resetn) begin
        if (!resetn) state <= SAMPLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            SAMPLE:  state_nxt = SETTLE;
            SETTLE: begin
                if (!raw_match)            state_nxt = SAMPLE;
                else if (cnt == CNT_LAST)  state_nxt = COMMIT;
            end
            COMMIT:  state_nxt = SAMPLE;
            default: state_nxt = SAMPLE;
        endcase
    end

    // A bouncing port abandons its visit and hands over to the next port rather than retrying.
    always_comb begin
        load_cand  = 1'b0;
        cnt_inc    = 1'b0;
        next_port  = 1'b0;
        commit_new = 1'b0;
        case (state)
            SAMPLE: load_cand = 1'b1;
            SETTLE: begin
                if (!raw_match)           next_port = 1'b1;
                else if (cnt != CNT_LAST) cnt_inc   = 1'b1;
            end
            COMMIT: begin
                next_port  = 1'b1;
                commit_new = (cand != stable_sel);
            end
            default: ;
        endcase
    end

    // Clear only the bits that were visible to this status read; a same-cycle commit still sets.
    always_comb begin
        chg_clr = (rd_en && addr[7:2] == IO_STATUS) ? chg : '0;
        for (int i = 0; i < NPORTS; i++) begin
            chg_set[i] = commit_new && (port_idx == PW'(i));
        end
    end

    // NOTE: stable[] is a handful of flops read straight onto the bus, so it is reset, unlike a RAM.
    always_ff @(posedge io_clk or negedge resetn) begin
        if (!resetn) begin
            port_idx <= '0;
            cnt      <= '0;
            cand     <= '0;
            chg      <= '0;
            for (int i = 0; i < NPORTS; i++) stable[i] <= '0;
        end else begin
            if (load_cand) begin
                cand <= raw_sel;
                cnt  <= '0;
            end else if (cnt_inc) begin
                cnt <= cnt + 1'b1;
            end
            if (next_port) begin
                port_idx <= (port_idx == LAST_PORT) ? '0 : port_idx + 1'b1;
            end
            for (int i = 0; i < NPORTS; i++) begin
                if (chg_set[i]) stable[i] <= cand;
            end
            chg <= (chg & ~chg_clr) | chg_set;
        end
    end

    io_scan_read_mux #(.NPORTS(NPORTS)) u_read_mux (
        .sel         (addr[7:2]),
        .stable_flat (stable_flat),
        .chg         (chg),
        .rd_data     (io_read_data)
    );

    assign change_irq = irq_en & (|chg);

endmodule

// File: tb/tb_io_input_scanner.sv
// Directed bench for io_input_scanner: stimulus queues expected read values, a monitor
// pops and compares them whenever a sample is presented.
module tb_io_input_scanner;

    localparam int NPORTS   = 2;
    localparam int DEBOUNCE = 4;

    logic        io_clk = 1'b0;
    logic        resetn = 1'b0;
    logic [31:0] port0_raw, port1_raw, bounce_val;
    logic        bounce_en;
    logic [63:0] in_ports;
    logic [31:0] addr;
    logic        rd_en, irq_en;
    logic [31:0] io_read_data;
    logic        change_irq;

    typedef struct {
        string       name;
        bit          is_irq;
        logic [31:0] expv;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    logic req = 1'b0;
    event sample_ev;

    assign in_ports = {port1_raw, bounce_en ? bounce_val : port0_raw};

    always #5 io_clk = ~io_clk;

    io_input_scanner #(.NPORTS(NPORTS), .DEBOUNCE(DEBOUNCE)) dut (
        .io_clk       (io_clk),
        .resetn       (resetn),
        .in_ports     (in_ports),
        .addr         (addr),
        .rd_en        (rd_en),
        .irq_en       (irq_en),
        .io_read_data (io_read_data),
        .change_irq   (change_irq)
    );

    task automatic check();
        exp_t        e;
        logic [31:0] act;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_sample: got %h with no expected entry", io_read_data);
        end else begin
            e   = exp_q.pop_front();
            act = e.is_irq ? {31'b0, change_irq} : io_read_data;
            if (act !== e.expv) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, act, e.expv);
            end
        end
    endtask

    always @(negedge io_clk) if (req) -> sample_ev;

    initial begin
        forever begin
            @(sample_ev);
            check();
        end
    end

    initial begin
        bounce_val = 32'h0;
        forever begin
            @(posedge io_clk);
            #1;
            bounce_val = bounce_val ^ 32'h5;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // One cycle: present addr/rd_en from posedge+1, sampled at the following negedge.
    task automatic peek(input logic [7:0] a, input logic re, input logic [31:0] e,
                        input string nm, input bit is_irq = 1'b0);
        addr  = {24'h0, a};
        rd_en = re;
        exp_q.push_back('{nm, is_irq, e});
        req = 1'b1;
        @(posedge io_clk);
        #1;
        req   = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic direct(input logic [7:0] a, input logic [31:0] e, input string nm);
        addr = {24'h0, a};
        #1;
        exp_q.push_back('{nm, 1'b0, e});
        -> sample_ev;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge io_clk);
            #1;
        end
    endtask

    task automatic wait_for(input logic [7:0] a, input logic [31:0] e, input int budget);
        bit hit = 1'b0;
        addr  = {24'h0, a};
        rd_en = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge io_clk);
            if (io_read_data === e) begin
                hit = 1'b1;
                break;
            end
            @(posedge io_clk);
            #1;
        end
        if (hit) begin
            @(posedge io_clk);
            #1;
        end
    endtask

    initial begin
        resetn    = 1'b0;
        port0_raw = 32'hFFFF_FFFF;
        port1_raw = 32'hFFFF_FFFF;
        bounce_en = 1'b0;
        addr      = 32'h0;
        rd_en     = 1'b0;
        irq_en    = 1'b0;
        @(posedge io_clk);
        #1;

        // Reset state with all-ones inputs.
        peek(8'h80, 1'b0, 32'h0, "rst_p0");
        peek(8'h84, 1'b0, 32'h0, "rst_p1");
        peek(8'hC0, 1'b0, 32'h0, "rst_status");
        peek(8'hC0, 1'b0, 32'h0, "rst_irq", 1'b1);
        resetn = 1'b1;
        idle(20);
        peek(8'h80, 1'b0, 32'hFFFF_FFFF, "init_p0");
        peek(8'h84, 1'b0, 32'hFFFF_FFFF, "init_p1");
        peek(8'hC0, 1'b0, 32'h3, "init_status");
        peek(8'h88, 1'b0, 32'h0, "unmapped_88");
        peek(8'h00, 1'b0, 32'h0, "unmapped_00");
        peek(8'h80, 1'b1, 32'hFFFF_FFFF, "p0_read_strobe");
        peek(8'hC0, 1'b0, 32'h3, "status_after_port_rd");
        peek(8'hC0, 1'b1, 32'h3, "status_clr_read");
        peek(8'hC0, 1'b0, 32'h0, "status_cleared");

        // Debounce: toggle every 2 cycles, value must not move.
        for (int i = 0; i < 40; i++) begin
            port0_raw = ((i & 2) != 0) ? 32'h0 : 32'h5;
            peek(8'h80, 1'b0, 32'hFFFF_FFFF, "toggle_hold_p0");
        end
        port0_raw = 32'h5;
        wait_for(8'h80, 32'h5, 18);
        peek(8'h80, 1'b0, 32'h5, "debounced_p0");
        peek(8'hC0, 1'b1, 32'h1, "debounce_status");

        // Starvation: port0 bounces every cycle while port1 steps.
        bounce_en = 1'b1;
        port1_raw = 32'h1234;
        wait_for(8'h84, 32'h1234, 18);
        peek(8'h84, 1'b0, 32'h1234, "starve_p1");
        peek(8'hC0, 1'b0, 32'h2, "starve_status");
        bounce_en = 1'b0;
        port0_raw = 32'h5;
        peek(8'hC0, 1'b1, 32'h2, "starve_status_clr");

        // Clear race: port0 commits at E6, port1 commits at E12 under a status read.
        resetn    = 1'b0;
        port0_raw = 32'hA;
        port1_raw = 32'h77;
        idle(2);
        resetn = 1'b1;
        idle(11);
        peek(8'hC0, 1'b1, 32'h1, "race_read");
        peek(8'hC0, 1'b0, 32'h2, "race_after");
        peek(8'hC0, 1'b1, 32'h2, "race_clr");

        // irq: port1 visit commits at E24.
        irq_en    = 1'b1;
        port1_raw = 32'h88;
        idle(8);
        peek(8'h00, 1'b0, 32'h0, "irq_idle", 1'b1);
        peek(8'h00, 1'b0, 32'h0, "irq_in_commit", 1'b1);
        peek(8'h00, 1'b0, 32'h1, "irq_rise", 1'b1);
        peek(8'hC0, 1'b1, 32'h2, "irq_status_read");
        peek(8'h00, 1'b0, 32'h0, "irq_fall", 1'b1);

        // Async reset while port0 is in SETTLE.
        peek(8'h84, 1'b0, 32'h88, "pre_reset_p1");
        #1;
        resetn = 1'b0;
        direct(8'h84, 32'h0, "async_p1");
        direct(8'h80, 32'h0, "async_p0");
        repeat (2) @(posedge io_clk);
        #1;
        resetn = 1'b1;
        idle(4);
        peek(8'h80, 1'b0, 32'h0, "restart_p0_settle");
        peek(8'h80, 1'b0, 32'h0, "restart_p0_pre_commit");
        peek(8'h80, 1'b0, 32'hA, "restart_p0_commit");
        peek(8'h84, 1'b0, 32'h0, "restart_p1_pending");
        idle(4);
        peek(8'h84, 1'b0, 32'h88, "restart_p1_commit");
        peek(8'hC0, 1'b0, 32'h3, "restart_status");

        idle(1);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
